// File: rtl/signed_seq_divider.sv
// Sequential signed divider: restoring division on operand magnitudes, one quotient
// bit per cycle, with sign fix-up, divide-by-zero and overflow reporting.
module signed_seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {IDLE, SETUP, ITER, FIXUP, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] qr_q, qr_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH:0]   dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sign_q_q, sign_q_d;
  logic             sign_r_q, sign_r_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    qr_d        = qr_q;
    rem_d       = rem_q;
    dvs_d       = dvs_q;
    cnt_d       = cnt_q;
    sign_q_d    = sign_q_q;
    sign_r_d    = sign_r_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    ovf_d       = ovf_q;

    // Magnitudes fit WIDTH bits unsigned, so the most negative operand is exact.
    a_mag   = a_q[WIDTH-1] ? -a_q : a_q;
    b_mag   = b_q[WIDTH-1] ? -b_q : b_q;
    shifted = {rem_q, qr_q[WIDTH-1]};
    diff    = shifted - {1'b0, dvs_q};
    q_fix   = sign_q_q ? -qr_q : qr_q;
    r_fix   = sign_r_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = dividend;
          b_d     = divisor;
          dbz_d   = 1'b0;
          ovf_d   = 1'b0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        qr_d     = a_mag;
        dvs_d    = {1'b0, b_mag};
        rem_d    = '0;
        cnt_d    = CW'(WIDTH);
        sign_q_d = a_q[WIDTH-1] ^ b_q[WIDTH-1];
        sign_r_d = a_q[WIDTH-1];
        if (b_q == '0) begin
          quotient_d  = '1;
          remainder_d = a_q;
          dbz_d       = 1'b1;
          state_d     = DONE;
        end else begin
          state_d = ITER;
        end
      end
      ITER: begin
        // A clear sign bit on the trial difference means the divisor fit.
        qr_d  = {qr_q[WIDTH-2:0], ~diff[WIDTH+1]};
        rem_d = diff[WIDTH+1] ? shifted[WIDTH:0] : diff[WIDTH:0];
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = FIXUP;
        end
      end
      FIXUP: begin
        quotient_d  = q_fix;
        remainder_d = r_fix;
        // Only a positive magnitude of 2^(WIDTH-1) cannot be represented.
        ovf_d       = ~sign_q_q & qr_q[WIDTH-1];
        state_d     = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      qr_q        <= '0;
      rem_q       <= '0;
      dvs_q       <= '0;
      cnt_q       <= '0;
      sign_q_q    <= 1'b0;
      sign_r_q    <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      qr_q        <= qr_d;
      rem_q       <= rem_d;
      dvs_q       <= dvs_d;
      cnt_q       <= cnt_d;
      sign_q_q    <= sign_q_d;
      sign_r_q    <= sign_r_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      ovf_q       <= ovf_d;
    end
  end

  assign busy        = (state_q == SETUP) || (state_q == ITER) || (state_q == FIXUP);
  assign done        = (state_q == DONE);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_signed_seq_divider.sv
// Randomized and directed checks of signed_seq_divider against an integer-arithmetic
// reference model; one line printed per division.
module tb_signed_seq_divider;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
  logic         overflow;

  int n_tests = 0;
  int n_fail  = 0;

  signed_seq_divider #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: C-style truncating division; remainder follows the dividend sign.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] q, output logic [W-1:0] r,
                                output logic dz, output logic ov);
    int ai, bi, qi, ri;
    ai = int'($signed(a));
    bi = int'($signed(b));
    dz = 1'b0;
    ov = 1'b0;
    if (bi == 0) begin
      q  = '1;
      r  = a;
      dz = 1'b1;
    end else if (ai == -(2 ** (W - 1)) && bi == -1) begin
      q  = {1'b1, {(W-1){1'b0}}};
      r  = '0;
      ov = 1'b1;
    end else begin
      qi = ai / bi;
      ri = ai % bi;
      q  = W'(qi);
      r  = W'(ri);
    end
  endfunction

  task automatic check_result(input string pfx, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] eq, er;
    logic         edz, eov;
    model(a, b, eq, er, edz, eov);
    check({pfx, "_quotient"}, quotient, eq);
    check({pfx, "_remainder"}, remainder, er);
    check({pfx, "_div_by_zero"}, div_by_zero, edz);
    check({pfx, "_overflow"}, overflow, eov);
    check({pfx, "_busy_in_done"}, busy, 0);
    $display("[TB] %s %0d / %0d -> q=%0d r=%0d dz=%0b ov=%0b", pfx, $signed(a), $signed(b),
             $signed(quotient), $signed(remainder), div_by_zero, overflow);
  endtask

  // One division; operand inputs are scrambled while busy, and an optional stray
  // start with fresh operands is pulsed in cycle 4.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit inject);
    logic [W-1:0] eq, er;
    logic         edz, eov;
    int           cycles;
    model(a, b, eq, er, edz, eov);
    @(negedge clk);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(negedge clk);
    start  = 1'b0;
    cycles = 1;
    check("busy_setup", busy, 1);
    check("done_early", done, 0);
    while (cycles < 40) begin
      @(negedge clk);
      cycles++;
      if (done) break;
      start    = inject && (cycles == 4);
      dividend = W'($urandom);
      divisor  = W'($urandom);
    end
    start = 1'b0;
    check("latency", cycles, edz ? 2 : W + 3);
    check_result("op", a, b);
    @(negedge clk);
    check("done_pulse_width", done, 0);
    check("quotient_hold", quotient, eq);
  endtask

  int da[9] = '{100, -100, -100, 100, 7, 50, -128, -128, -128};
  int db[9] = '{7, 7, -7, -7, 0, 5, -1, 1, 3};

  initial begin
    int           seen;
    int           t;
    logic [W-1:0] ra, rb;

    reset    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_div_by_zero", div_by_zero, 0);
    check("rst_overflow", overflow, 0);
    reset = 1'b0;

    for (int i = 0; i < 9; i++) begin
      run_op(W'(da[i]), W'(db[i]), i == 0);
    end

    // Reset in cycle 5 of an operation discards it.
    @(negedge clk);
    start    = 1'b1;
    dividend = W'(100);
    divisor  = W'(7);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_quotient", quotient, 0);
    check("midrst_remainder", remainder, 0);
    check("midrst_div_by_zero", div_by_zero, 0);
    check("midrst_overflow", overflow, 0);
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("midrst_no_done", seen, 0);
    $display("[TB] reset mid-operation, done pulses afterwards=%0d", seen);
    run_op(W'(50), W'(5), 1'b0);

    // Back-to-back: start raised in the done cycle, accepted one cycle later.
    @(negedge clk);
    start    = 1'b1;
    dividend = W'(-77);
    divisor  = W'(9);
    @(negedge clk);
    start = 1'b0;
    t = 1;
    while (t < 40 && !done) begin
      @(negedge clk);
      t++;
    end
    check("b2b_first_latency", t, W + 3);
    check_result("b2b_first", W'(-77), W'(9));
    start    = 1'b1;
    dividend = W'(123);
    divisor  = W'(-7);
    t = 0;
    while (t < 40) begin
      @(negedge clk);
      t++;
      if (t == 2) start = 1'b0;
      if (done) break;
    end
    start = 1'b0;
    check("b2b_gap", t, 12);
    check_result("b2b_second", W'(123), W'(-7));

    for (int i = 0; i < 60; i++) begin
      int sel;
      ra  = W'($urandom);
      sel = $urandom_range(0, 7);
      if (sel == 0)      rb = '0;
      else if (sel == 1) rb = '1;
      else               rb = W'($urandom);
      if ($urandom_range(0, 5) == 0) ra = {1'b1, {(W-1){1'b0}}};
      run_op(ra, rb, $urandom_range(0, 1) == 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/signed_seq_divider.md
# signed_seq_divider

Sequential signed two's-complement divider that computes quotient and remainder one bit per cycle, using restoring division on operand magnitudes. It is the inverse companion to the signed array multiplier datapath. A multiply-then-divide check can recover the original operand. It sits beside the multiplier under a shared start/done handshake and reuses the same sign-handling rules as the multiplier's sign-extension logic.

## Interface
- WIDTH, 8: operand and result width in bits; WIDTH ≥ 2.
- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- dividend  input  WIDTH  signed dividend; captured on an accepted start.
- divisor  input  WIDTH  signed divisor; captured on an accepted start.
- busy  output  1  high from the cycle after an accepted start through the cycle before done.
- done  output  1  one-cycle pulse; results valid from this cycle on.
- quotient  output  WIDTH  signed quotient, truncated toward zero.
- remainder  output  WIDTH  signed remainder; takes the sign of the dividend.
- div_by_zero  output  1  set with done when divisor == 0.
- overflow  output  1  set with done for dividend = −2^(WIDTH−1) and divisor = −1.

## Operation
- States: IDLE, SETUP, ITER, FIXUP, DONE.
- IDLE: start=1 captures both operands and moves to SETUP. start=0 stays in IDLE.
- SETUP:
  - Form WIDTH+1-bit magnitudes |dividend| and |divisor|, so −2^(WIDTH−1) is exact.
  - Record sign_q = sign(dividend) XOR sign(divisor) and sign_r = sign(dividend).
  - Clear the partial remainder and load the iteration counter with WIDTH.
  - If divisor == 0, go directly to DONE.
  - Otherwise go to ITER.
- ITER, one quotient bit per cycle, MSB first:
  - Shift {partial remainder, dividend magnitude} left by 1.
  - Trial-subtract the divisor magnitude at WIDTH+1 bits.
  - If the result is non-negative, keep it and set the quotient bit to 1. Otherwise restore and set it to 0.
  - Decrement the counter. When it reaches 0, go to FIXUP.
- FIXUP:
  - Negate the quotient magnitude if sign_q. Negate the remainder magnitude if sign_r.
  - Truncate both to WIDTH bits; the quotient wraps modulo 2^WIDTH.
  - Set overflow when the true quotient is +2^(WIDTH−1); the stored quotient is then −2^(WIDTH−1), remainder 0.
  - Go to DONE.
- DONE: register all results, pulse done, return to IDLE.
- Divide by zero: quotient = all ones, remainder = dividend, div_by_zero = 1, overflow = 0.
- div_by_zero and overflow are both cleared on the next accepted start.
- quotient, remainder, div_by_zero and overflow hold their values until the next DONE or reset.
- start while not in IDLE is ignored. Operand input changes after capture have no effect.
- Invariant when div_by_zero = 0 and overflow = 0: dividend == quotient·divisor + remainder, and |remainder| < |divisor|.

## Timing
- Start accepted at clock edge 0:
  - SETUP during cycle 1.
  - ITER during cycles 2 … WIDTH+1.
  - FIXUP during cycle WIDTH+2.
  - done high during cycle WIDTH+3.
  - Latency is WIDTH+3 cycles (11 for WIDTH=8).
- Divide-by-zero path: done high during cycle 2.
- busy is high during cycles 1 … WIDTH+2 and low in the done cycle.
- Back-to-back operation: start may be asserted in the done cycle. It is sampled one cycle later, when the block is back in IDLE.
- Throughput: at most one division per WIDTH+4 cycles.
- Reset, including in the middle of an operation, takes effect at the next edge:
  - State returns to IDLE.
  - busy = 0, done = 0, div_by_zero = 0, overflow = 0.
  - quotient = 0, remainder = 0.
  - The in-flight operation is discarded and no done is produced.

## Test plan
- WIDTH=8, 100 / 7 → done exactly 11 cycles after start; quotient=14, remainder=2, both flags 0.
- −100 / 7 → quotient=0xF2 (−14), remainder=0xFE (−2). −100 / −7 → quotient=14, remainder=0xFE (−2). 100 / −7 → quotient=0xF2, remainder=2.
- 7 / 0 → done 2 cycles after start; quotient=0xFF, remainder=7, div_by_zero=1. The next valid division clears the flag.
- −128 / −1 → quotient=0x80, remainder=0, overflow=1. −128 / 1 → quotient=0x80, overflow=0. −128 / 3 → quotient=0xD6 (−42), remainder=0xFE (−2).
- Assert start with new operands in cycle 4 of a busy operation → ignored; the original result is delivered unchanged. Start asserted in the done cycle → second result arrives 12 cycles after the first done.
- Assert reset in cycle 5 of an operation → all outputs 0 and busy=0 on the next edge, no done pulse; a fresh 50 / 5 then yields quotient=10, remainder=0.
